// File: rtl/range_tracker.sv
// range_tracker: tracks min/max/count of valid samples between go and finish
// edges and reports range, min, max or count as a registered result.
module range_tracker #(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             go,
    input  logic             finish,
    input  logic [1:0]       mode,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             busy,
    output logic             error,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, ACQ, DONE, ERROR} state_t;
    state_t state;
    logic go_q, fin_q, go_arm, fin_arm, go_pos, fin_pos;
    logic start, take, first, lt, gt, nxt_ovf, to_done, to_err;
    logic [WIDTH-1:0] min_v, max_v, nxt_min, nxt_max;
    logic [CNT_W-1:0] count, base_cnt, nxt_count;
    logic [1:0] mode_q, nxt_mode;
    logic [WIDTH:0] rng, res;

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
        return {SIGNED ? x[WIDTH-1] : 1'b0, x};
    endfunction

    // The arm flags block a spurious edge when go/finish is already high at reset release.
    assign go_pos  = go & ~go_q & go_arm;
    assign fin_pos = finish & ~fin_q & fin_arm;
    assign start   = go_pos && (state == IDLE || state == ERROR);
    assign take    = data_valid && (start || (state == ACQ && !go_pos));
    assign base_cnt = start ? '0 : count;
    assign first   = base_cnt == '0;
    assign lt      = $signed(ext(data_in)) < $signed(ext(min_v));
    assign gt      = $signed(ext(data_in)) > $signed(ext(max_v));
    assign nxt_min = (take && (first || lt)) ? data_in : min_v;
    assign nxt_max = (take && (first || gt)) ? data_in : max_v;
    assign nxt_count = (take && !(&base_cnt)) ? base_cnt + 1'b1 : base_cnt;
    assign nxt_ovf = (start ? 1'b0 : overflow) | (&nxt_count);
    assign nxt_mode = start ? mode : mode_q;
    assign to_done = state == ACQ && !go_pos && fin_pos && nxt_count != '0;
    assign to_err  = (state == IDLE && fin_pos && !go_pos) ||
                     (state == ACQ && (go_pos || (fin_pos && nxt_count == '0)));
    assign rng = ext(nxt_max) - ext(nxt_min);
    assign res = nxt_mode == 2'd0 ? rng :
                 nxt_mode == 2'd1 ? {1'b0, nxt_min} :
                 nxt_mode == 2'd2 ? {1'b0, nxt_max} : (WIDTH+1)'(nxt_count);
    assign busy  = state == ACQ;
    assign error = state == ERROR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            go_q         <= 1'b0;
            fin_q        <= 1'b0;
            go_arm       <= 1'b0;
            fin_arm      <= 1'b0;
            min_v        <= '0;
            max_v        <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            mode_q       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            go_q         <= go;
            fin_q        <= finish;
            go_arm       <= go_arm | ~go;
            fin_arm      <= fin_arm | ~finish;
            min_v        <= nxt_min;
            max_v        <= nxt_max;
            count        <= nxt_count;
            overflow     <= nxt_ovf;
            mode_q       <= nxt_mode;
            result_valid <= to_done;
            if (to_done) result <= res;
            state <= start ? ACQ : to_err ? ERROR : to_done ? DONE :
                     state == DONE ? IDLE : state;
        end
    end
endmodule

// File: tb/tb_range_tracker.sv
// tb_range_tracker: directed table-driven checks of range_tracker in unsigned,
// signed and narrow-counter configurations driven by shared inputs.
module tb_range_tracker;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic data_valid = 1'b0, go = 1'b0, finish = 1'b0;
    logic [1:0] mode = '0;
    logic [8:0] res_u, res_s, res_c;
    logic rv_u, rv_s, rv_c, busy_u, busy_s, busy_c, err_u, err_s, err_c, ovf_u, ovf_s, ovf_c;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    range_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid), .go(go),
        .finish(finish), .mode(mode), .result(res_u), .result_valid(rv_u), .busy(busy_u),
        .error(err_u), .overflow(ovf_u));
    range_tracker #(.WIDTH(8), .CNT_W(8), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid), .go(go),
        .finish(finish), .mode(mode), .result(res_s), .result_valid(rv_s), .busy(busy_s),
        .error(err_s), .overflow(ovf_s));
    range_tracker #(.WIDTH(8), .CNT_W(3), .SIGNED(1'b0)) dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid), .go(go),
        .finish(finish), .mode(mode), .result(res_c), .result_valid(rv_c), .busy(busy_c),
        .error(err_c), .overflow(ovf_c));

    typedef struct {
        logic go, fin, dv;
        logic [7:0] d;
        logic [1:0] mode;
        logic [8:0] res;
        logic rv, busy, err;
    } vec_t;
    vec_t tv[34];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic g, input logic f, input logic v, input logic [7:0] d,
                         input logic [1:0] m);
        go = g; finish = f; data_valid = v; data_in = d; mode = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd0,   1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 1'b0, 8'd0,   2'd0, 9'd0,   1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 1'b1, 8'd20,  2'd0, 9'd0,   1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 1'b1, 8'd5,   2'd0, 9'd0,   1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 1'b1, 8'd90,  2'd0, 9'd0,   1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b1, 8'd41,  2'd0, 9'd0,   1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd0, 9'd85,  1'b1, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd0, 9'd85,  1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd85,  1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b1, 1'b0, 8'd0,   2'd0, 9'd85,  1'b0, 1'b0, 1'b1};
        tv[10] = '{1'b1, 1'b1, 1'b1, 8'd7,   2'd0, 9'd85,  1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b1, 1'b0, 1'b1, 8'd3,   2'd0, 9'd85,  1'b0, 1'b1, 1'b0};
        tv[12] = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd1, 9'd4,   1'b1, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd4,   1'b0, 1'b0, 1'b0};
        tv[14] = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd2, 9'd4,   1'b0, 1'b1, 1'b0};
        tv[15] = '{1'b1, 1'b0, 1'b1, 8'd200, 2'd2, 9'd4,   1'b0, 1'b1, 1'b0};
        tv[16] = '{1'b1, 1'b1, 1'b1, 8'd250, 2'd2, 9'd250, 1'b1, 1'b0, 1'b0};
        tv[17] = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd250, 1'b0, 1'b0, 1'b0};
        tv[18] = '{1'b1, 1'b0, 1'b0, 8'd0,   2'd3, 9'd250, 1'b0, 1'b1, 1'b0};
        tv[19] = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd3, 9'd250, 1'b0, 1'b0, 1'b1};
        tv[20] = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd250, 1'b0, 1'b0, 1'b1};
        tv[21] = '{1'b1, 1'b0, 1'b1, 8'd9,   2'd3, 9'd250, 1'b0, 1'b1, 1'b0};
        tv[22] = '{1'b1, 1'b0, 1'b1, 8'd9,   2'd3, 9'd250, 1'b0, 1'b1, 1'b0};
        tv[23] = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd3, 9'd2,   1'b1, 1'b0, 1'b0};
        tv[24] = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd2,   1'b0, 1'b0, 1'b0};
        tv[25] = '{1'b1, 1'b0, 1'b1, 8'd10,  2'd0, 9'd2,   1'b0, 1'b1, 1'b0};
        tv[26] = '{1'b0, 1'b0, 1'b1, 8'd50,  2'd0, 9'd2,   1'b0, 1'b1, 1'b0};
        tv[27] = '{1'b1, 1'b0, 1'b1, 8'd255, 2'd0, 9'd2,   1'b0, 1'b0, 1'b1};
        tv[28] = '{1'b1, 1'b1, 1'b0, 8'd0,   2'd0, 9'd2,   1'b0, 1'b0, 1'b1};
        tv[29] = '{1'b0, 1'b0, 1'b0, 8'd0,   2'd0, 9'd2,   1'b0, 1'b0, 1'b1};
        tv[30] = '{1'b1, 1'b0, 1'b1, 8'd4,   2'd1, 9'd2,   1'b0, 1'b1, 1'b0};
        tv[31] = '{1'b0, 1'b1, 1'b0, 8'd0,   2'd1, 9'd4,   1'b1, 1'b0, 1'b0};
        tv[32] = '{1'b1, 1'b0, 1'b0, 8'd0,   2'd0, 9'd4,   1'b0, 1'b0, 1'b0};
        tv[33] = '{1'b1, 1'b0, 1'b0, 8'd0,   2'd0, 9'd4,   1'b0, 1'b0, 1'b0};

        #12;
        chk("reset result", res_u, 9'd0);
        chk("reset busy", busy_u, 1'b0);
        chk("reset error", err_u, 1'b0);
        chk("reset rv", rv_u, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

        for (int i = 0; i < 34; i++) begin
            drive(tv[i].go, tv[i].fin, tv[i].dv, tv[i].d, tv[i].mode);
            chk($sformatf("v%0d result", i), res_u, tv[i].res);
            chk($sformatf("v%0d result_valid", i), rv_u, tv[i].rv);
            chk($sformatf("v%0d busy", i), busy_u, tv[i].busy);
            chk($sformatf("v%0d error", i), err_u, tv[i].err);
            chk($sformatf("v%0d overflow", i), ovf_u, 1'b0);
        end

        // Signed vs unsigned on the same -100/+100 samples.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 8'h9C, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 8'h64, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        chk("signed range", res_s, 9'd200);
        chk("signed range rv", rv_s, 1'b1);
        chk("unsigned range", res_u, 9'd56);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd1);
        drive(1'b1, 1'b0, 1'b1, 8'h9C, 2'd0);
        drive(1'b1, 1'b0, 1'b1, 8'h64, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        chk("signed min", res_s, 9'h09C);
        chk("unsigned min", res_u, 9'h064);

        // Count saturation on the 3-bit counter instance.
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd3);
        chk("cnt start ovf", ovf_c, 1'b0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(i), 2'd3);
            if (i == 5) chk("ovf after 6", ovf_c, 1'b0);
            if (i == 6) chk("ovf after 7", ovf_c, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b0, 8'd0, 2'd3);
        chk("sat count", res_c, 9'd7);
        chk("sat rv", rv_c, 1'b1);
        chk("sat ovf", ovf_c, 1'b1);
        chk("wide count", res_u, 9'd9);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        chk("ovf sticky", ovf_c, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        chk("ovf cleared", ovf_c, 1'b0);
        chk("cnt busy", busy_c, 1'b1);

        // Asynchronous reset mid-run with go held high through release.
        drive(1'b1, 1'b0, 1'b1, 8'd33, 2'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async busy", busy_u, 1'b0);
        chk("async result", res_u, 9'd0);
        chk("async ovf", ovf_c, 1'b0);
        chk("async rv", rv_u, 1'b0);
        #2 rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd0);
        chk("held go idle", busy_u, 1'b0);
        chk("held go no result", rv_u, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 2'd2);
        chk("rearmed go", busy_u, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 8'd8, 2'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 2'd0);
        chk("post reset max", res_u, 9'd8);
        chk("post reset rv", rv_u, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
